sram_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the single-port `sram` macro. It accepts byte, halfword and word load/store requests on a valid/ready interface and checks alignment and address range. It generates the SRAM chip-select, byte-lane write enables and lane-replicated write data. For reads it captures the SRAM's combinational `RDATA`, then aligns and sign- or zero-extends it before returning a response on a second valid/ready channel.

---
 rtl/sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Request-side controller for a single-port SRAM macro: checks alignment and range,
// drives chip-select, byte-lane write enables and replicated write data, and aligns/extends load data.
module sram_ctrl #(
  parameter int          DATAWIDTH = 32,
  parameter int          ADDRWIDTH = 16,
  parameter logic [31:0] MEMBASE   = 32'h0000_0000,
  parameter logic [31:0] MEMTOP    = 32'h0003_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ADDRWIDTH-1:0] sram_addr,
  output logic                 sram_cs,
  output logic [3:0]           sram_we,
  output logic [DATAWIDTH-1:0] sram_wdata,
  input  logic [DATAWIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state, state_nxt;
  logic                   r_write;
  logic [1:0]             r_size;
  logic                   r_signed;
  logic [1:0]             r_lane;
  logic [ADDRWIDTH-1:0]   r_word;
  logic [31:0]            r_wdata;
  logic                   r_err;
  logic [31:0]            rdata_q;

  // 33-bit subtractions: the borrow bit flags below-base / above-top without constant compares
  logic [32:0]            base_calc;
  logic [32:0]            top_calc;
  logic                   req_err;
  logic                   unused_bits;

  assign base_calc = {1'b0, req_addr} - {1'b0, MEMBASE};
  assign top_calc  = {1'b0, MEMTOP} - {1'b0, req_addr};
  assign unused_bits = ^{base_calc[31:ADDRWIDTH+2], base_calc[1:0], top_calc[31:0]};

  assign req_err = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (|req_addr[1:0]))
                 | base_calc[32]
                 | top_calc[32];

  logic [3:0]  lane_we;
  logic [31:0] rep_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    lane_we   = 4'b1111;
    rep_wdata = r_wdata;
    case (r_size)
      2'd0: begin
        lane_we   = 4'b0001 << r_lane;
        rep_wdata = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        lane_we   = 4'b0011 << r_lane;
        rep_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = sram_rdata >> {r_lane, 3'b000};

  always_comb begin
    load_data = shifted;
    case (r_size)
      2'd0:    load_data = {{24{r_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{r_signed & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!r_err) begin
          sram_cs    = 1'b1;
          sram_addr  = r_word;
          sram_we    = r_write ? lane_we : 4'b0000;
          sram_wdata = rep_wdata;
        end
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_rdata = (state == RESP) ? rdata_q : 32'h0;
  assign resp_err   = (state == RESP) & r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_lane   <= 2'd0;
      r_word   <= '0;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_lane   <= req_addr[1:0];
        r_word   <= base_calc[ADDRWIDTH+1:2];
        r_wdata  <= req_wdata;
        r_err    <= req_err;
      end
      if (state == ACCESS)
        rdata_q <= (!r_err && !r_write) ? load_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: byte-addressed reference memory model plus a per-cycle output checker.
module tb_sram_ctrl;

  localparam logic [31:0] MEMBASE = 32'h0000_0000;
  localparam logic [31:0] MEMTOP  = 32'h0003_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [15:0] sram_addr;
  logic        sram_cs;
  logic [3:0]  sram_we;
  logic [31:0] sram_wdata, sram_rdata;

  sram_ctrl #(.DATAWIDTH(32), .ADDRWIDTH(16), .MEMBASE(MEMBASE), .MEMTOP(MEMTOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro stand-in: combinational read, byte-lane write on the rising edge
  logic [31:0] stub [256];
  initial for (int i = 0; i < 256; i++) stub[i] <= 32'h0;
  assign sram_rdata = (sram_cs && sram_we == 4'b0000) ? stub[sram_addr[7:0]] : 32'h0;
  always @(posedge clk)
    if (sram_cs)
      for (int i = 0; i < 4; i++)
        if (sram_we[i]) stub[sram_addr[7:0]][8*i +: 8] <= sram_wdata[8*i +: 8];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory and spec rules in plain arithmetic
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || ((a % nbytes(sz)) != 0) || ((a - MEMBASE) > (MEMTOP - MEMBASE));
  endfunction

  function automatic logic [3:0] m_we(input logic [1:0] sz, input logic [31:0] a);
    logic [7:0] m;
    m = 8'((1 << nbytes(sz)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int nb;
    nb = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(rd_byte(a + 32'(i))) << (8 * i));
    if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // Expected outputs for the current cycle, maintained by the stimulus thread
  logic        exp_req_ready, exp_resp_valid, exp_resp_err, exp_cs, exp_chk_bus;
  logic [3:0]  exp_we;
  logic [15:0] exp_addr;
  logic [31:0] exp_wdata, exp_rdata;

  task automatic set_idle();
    exp_req_ready = 1'b1; exp_resp_valid = 1'b0; exp_resp_err = 1'b0; exp_rdata = 32'h0;
    exp_cs = 1'b0; exp_we = 4'h0; exp_addr = 16'h0; exp_wdata = 32'h0; exp_chk_bus = 1'b1;
  endtask

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(exp_req_ready));
    check("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
    check("sram_cs", 32'(sram_cs), 32'(exp_cs));
    check("sram_we", 32'(sram_we), 32'(exp_we));
    if (exp_chk_bus) begin
      check("sram_addr", 32'(sram_addr), 32'(exp_addr));
      check("sram_wdata", sram_wdata, exp_wdata);
    end
    if (exp_resp_valid) begin
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_err", 32'(resp_err), 32'(exp_resp_err));
    end
  end

  logic [31:0] o_rdata, o_wdata;
  logic        o_err, o_cs;
  logic [3:0]  o_we;
  logic [15:0] o_addr;

  // One full transaction; starts and ends one time unit after a rising edge with the DUT idle
  task automatic xact(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic e;
    logic [31:0] rd;
    int n;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_timeout", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom); req_size = 2'($urandom);
    e = m_err(sz, a);
    exp_req_ready = 1'b0; exp_resp_valid = 1'b0;
    exp_cs = !e;
    exp_we = (!e && w) ? m_we(sz, a) : 4'h0;
    exp_addr = 16'((a - MEMBASE) >> 2);
    exp_wdata = m_wdata(sz, wd);
    exp_chk_bus = !e;
    @(negedge clk);
    o_cs = sram_cs; o_we = sram_we; o_addr = sram_addr; o_wdata = sram_wdata;
    @(posedge clk); #1;
    rd = 32'h0;
    if (!e) begin
      if (w) for (int i = 0; i < nbytes(sz); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      else rd = m_load(sz, sg, a);
    end
    exp_cs = 1'b0; exp_we = 4'h0; exp_addr = 16'h0; exp_wdata = 32'h0; exp_chk_bus = 1'b1;
    exp_resp_valid = 1'b1; exp_rdata = rd; exp_resp_err = e;
    @(negedge clk);
    o_rdata = resp_rdata; o_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_resp_err", 32'(resp_err), 32'h0);
    check("reset_sram_cs", 32'(sram_cs), 32'h0);

    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    check("sw_cs", 32'(o_cs), 32'h1);
    check("sw_addr", 32'(o_addr), 32'h4);
    check("sw_we", 32'(o_we), 32'hF);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    check("lw_data", o_rdata, 32'hDEAD_BEEF);
    check("lw_err", 32'(o_err), 32'h0);

    xact(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 0);
    check("sb_we", 32'(o_we), 32'h8);
    check("sb_wdata", o_wdata, 32'h8080_8080);
    xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    check("lb_signed", o_rdata, 32'hFFFF_FF80);
    xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    check("lb_unsigned", o_rdata, 32'h0000_0080);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    check("lw_after_sb", o_rdata, 32'h80AD_BEEF);

    xact(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234, 0);
    check("sh_we", 32'(o_we), 32'hC);
    check("sh_wdata", o_wdata, 32'h1234_1234);
    xact(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
    check("lh_unsigned", o_rdata, 32'h0000_1234);
    xact(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 0);
    xact(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
    check("lh_signed", o_rdata, 32'hFFFF_8001);

    xact(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
    check("err_word_mis", 32'(o_err), 32'h1);
    check("err_word_cs", 32'(o_cs), 32'h0);
    xact(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_5555, 0);
    check("err_half_mis", 32'(o_err), 32'h1);
    check("err_half_cs", 32'(o_cs), 32'h0);
    xact(1'b1, 2'd3, 1'b0, 32'h40, 32'h1111_1111, 0);
    check("err_size3", 32'(o_err), 32'h1);
    check("err_size3_rdata", o_rdata, 32'h0);
    xact(1'b0, 2'd2, 1'b0, MEMTOP + 32'h1, 32'h0, 0);
    check("err_range", 32'(o_err), 32'h1);
    check("err_range_rdata", o_rdata, 32'h0);
    xact(1'b0, 2'd0, 1'b0, MEMTOP, 32'h0, 0);
    check("top_byte_ok", 32'(o_err), 32'h0);

    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
    check("bp_rdata", o_rdata, 32'h80AD_BEEF);

    // Reset during the ACCESS cycle of a store: the write must never land
    req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_req_ready = 1'b0; exp_cs = 1'b1; exp_we = 4'hF; exp_addr = 16'hC;
    exp_wdata = 32'hCAFE_F00D; exp_chk_bus = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_cs", 32'(sram_cs), 32'h0);
    check("rst_mid_we", 32'(sram_we), 32'h0);
    set_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_rel_req_ready", 32'(req_ready), 32'h1);
    check("rst_rel_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_word12", stub[12], 32'h0);
    xact(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);
    check("rst_word12_load", o_rdata, 32'h0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
